// File: rtl/bht_ctrl.sv
// bht_ctrl: arbitrates the shared BHT/BTB index port between fetch lookups
// and queued resolved-branch updates, and raises a registered redirect.
module bht_ctrl #(
  parameter int QDEPTH  = 4,
  parameter int AGE_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [31:0] f_pc,
  output logic        f_gnt,
  output logic        f_taken,
  output logic [31:0] f_target,
  input  logic        r_valid,
  input  logic [31:0] r_pc,
  input  logic        r_taken,
  input  logic [31:0] r_target,
  input  logic        r_pred,
  input  logic [31:0] r_ptgt,
  output logic        r_ready,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic [15:0] mispred_cnt,
  output logic [3:0]  bht_ind,
  output logic [31:0] bht_bta,
  output logic        bht_val,
  output logic        bht_br,
  input  logic        bht_taken,
  input  logic [31:0] bht_btp
);

  localparam int PW = $clog2(QDEPTH);
  localparam int AW = $clog2(AGE_MAX + 1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(QDEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [AW-1:0] AGE_LIM  = AW'(AGE_MAX);
  localparam logic [AW-1:0] AGE_ONE  = AW'(1);

  typedef struct packed {
    logic [3:0]  idx;
    logic        taken;
    logic [31:0] tgt;
  } upd_t;

  upd_t          mem_q [QDEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [AW-1:0] age_q, age_d;
  logic          red_q, red_d;
  logic [31:0]   rpc_q, rpc_d;
  logic [15:0]   mcnt_q, mcnt_d;

  logic empty;
  logic full;
  logic force_upd;
  logic upd_slot;
  logic push;
  logic pop;
  logic mispred;
  upd_t head;
  upd_t entry;

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CNT_FULL);
  assign head      = mem_q[rd_q];
  assign force_upd = !empty && (full || (age_q >= AGE_LIM));
  assign upd_slot  = !empty && (force_upd || !f_req);
  assign push      = r_valid && !full;
  assign pop       = upd_slot;

  assign mispred = (r_taken != r_pred)
                || (r_taken && r_pred && (r_target != r_ptgt));

  assign entry.idx   = r_pc[5:2];
  assign entry.taken = r_taken;
  assign entry.tgt   = r_target;

  assign r_ready  = !full;
  assign f_gnt    = f_req && !upd_slot;
  assign f_taken  = bht_taken && f_gnt;
  assign f_target = f_gnt ? bht_btp : 32'd0;

  assign bht_br  = upd_slot;
  assign bht_ind = upd_slot ? head.idx : f_pc[5:2];
  assign bht_val = upd_slot && head.taken;
  assign bht_bta = upd_slot ? head.tgt : 32'd0;

  assign redirect    = red_q;
  assign redirect_pc = rpc_q;
  assign mispred_cnt = mcnt_q;

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    age_d  = age_q;
    red_d  = 1'b0;
    rpc_d  = rpc_q;
    mcnt_d = mcnt_q;
    if (push) wr_d = wr_q + PTR_ONE;
    if (pop)  rd_d = rd_q + PTR_ONE;
    unique case (1'b1)
      push && !pop: cnt_d = cnt_q + CNT_ONE;
      pop && !push: cnt_d = cnt_q - CNT_ONE;
      default: ;
    endcase
    // Age belongs to whichever entry sits at the head next cycle
    if (empty || pop) begin
      age_d = '0;
    end else if (age_q != AGE_LIM) begin
      age_d = age_q + AGE_ONE;
    end
    if (push && mispred) begin
      red_d = 1'b1;
      rpc_d = r_taken ? r_target : r_pc + 32'd4;
      if (mcnt_q != 16'hFFFF) mcnt_d = mcnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      age_q  <= '0;
      red_q  <= 1'b0;
      rpc_q  <= 32'd0;
      mcnt_q <= 16'd0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      age_q  <= age_d;
      red_q  <= red_d;
      rpc_q  <= rpc_d;
      mcnt_q <= mcnt_d;
    end
  end

endmodule
